// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op encodings and the control bundle
// carried from ID through EX and MEM.
package pipeline_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_dst;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Control bits of a non-instruction must never have side effects.
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic keep);
    return keep ? c : '0;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the instruction in ID. Register 0 never hazards.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_valid_i,
  output logic              lu_o
);

  // Hazard when the loaded register matches any source the ID op reads.
  always_comb begin
    lu_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0) && id_valid_i &&
           ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, branch
// flush and downstream hold. Optional macro ID_EX_STALL_CNT_EN adds a
// saturating count of load-use bubbles on stall_cnt_o.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_uses_rt_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_branch_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_uses_rt_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_dst_o,
  output logic              ex_branch_o,
  output logic [3:0]        ex_alu_op_o,
  output logic              stall_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  logic              valid_d, valid_q;
  logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic              uses_rt_d, uses_rt_q;
  logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
  ctrl_t             ctrl_d, ctrl_q, id_ctrl;
  logic              lu;

  load_use_detect #(.REG_AW(REG_AW)) u_lu (
    .ex_rt_i       (rt_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_valid_i    (valid_q),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_valid_i    (id_valid_i),
    .lu_o          (lu)
  );

  // Bundle the incoming control bits.
  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = id_reg_write_i;
    id_ctrl.mem_read   = id_mem_read_i;
    id_ctrl.mem_write  = id_mem_write_i;
    id_ctrl.mem_to_reg = id_mem_to_reg_i;
    id_ctrl.alu_src    = id_alu_src_i;
    id_ctrl.reg_dst    = id_reg_dst_i;
    id_ctrl.branch     = id_branch_i;
    id_ctrl.alu_op     = id_alu_op_i;
  end

  // Stall only when the pipe will actually advance into a bubble.
  always_comb begin
    stall_o = lu && !flush_i && !hold_i;
  end

  // Next-state select: flush bubble > hold > load-use bubble > capture.
  always_comb begin
    valid_d   = valid_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    uses_rt_d = uses_rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    if (flush_i || (!hold_i && lu)) begin
      valid_d   = 1'b0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      uses_rt_d = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      ctrl_d    = '0;
    end else if (!hold_i) begin
      valid_d   = id_valid_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
      uses_rt_d = id_uses_rt_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      ctrl_d    = ctrl_gate(id_ctrl, id_valid_i);
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      uses_rt_q <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      uses_rt_q <= uses_rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Drive the EX-side outputs from the registered stage.
  always_comb begin
    ex_valid_o      = valid_q;
    ex_rs_o         = rs_q;
    ex_rt_o         = rt_q;
    ex_rd_o         = rd_q;
    ex_uses_rt_o    = uses_rt_q;
    ex_rs_data_o    = rs_data_q;
    ex_rt_data_o    = rt_data_q;
    ex_imm_o        = imm_q;
    ex_reg_write_o  = ctrl_q.reg_write;
    ex_mem_read_o   = ctrl_q.mem_read;
    ex_mem_write_o  = ctrl_q.mem_write;
    ex_mem_to_reg_o = ctrl_q.mem_to_reg;
    ex_alu_src_o    = ctrl_q.alu_src;
    ex_reg_dst_o    = ctrl_q.reg_dst;
    ex_branch_o     = ctrl_q.branch;
    ex_alu_op_o     = ctrl_q.alu_op;
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // stall_o high means this edge loads a load-use bubble; saturate at max.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Expose the count.
  always_comb begin
    stall_cnt_o = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// reset/stall sequence, then randomized traffic against a reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch;
    logic [3:0]  alu_op;
    logic        flush, hold;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch;
    logic [3:0]  alu_op;
  } ex_t;

  typedef struct {
    in_t        in;
    logic       exp_stall;
    logic       exp_valid;
    logic [4:0] exp_rs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur = '0;
  ex_t  act;
  ex_t  m = '0;
  logic [31:0] m_cnt = '0;
  logic primed = 1'b0;
  int errors = 0;
  int checks = 0;

  logic        ex_valid_o, ex_uses_rt_o, stall_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
  logic        ex_alu_src_o, ex_reg_dst_o, ex_branch_o;
  logic [3:0]  ex_alu_op_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(cur.rst), .id_valid_i(cur.valid),
    .id_rs_i(cur.rs), .id_rt_i(cur.rt), .id_rd_i(cur.rd), .id_uses_rt_i(cur.uses_rt),
    .id_rs_data_i(cur.rs_data), .id_rt_data_i(cur.rt_data), .id_imm_i(cur.imm),
    .id_reg_write_i(cur.reg_write), .id_mem_read_i(cur.mem_read),
    .id_mem_write_i(cur.mem_write), .id_mem_to_reg_i(cur.mem_to_reg),
    .id_alu_src_i(cur.alu_src), .id_reg_dst_i(cur.reg_dst), .id_branch_i(cur.branch),
    .id_alu_op_i(cur.alu_op), .flush_i(cur.flush), .hold_i(cur.hold),
    .ex_valid_o(ex_valid_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_uses_rt_o(ex_uses_rt_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_reg_dst_o(ex_reg_dst_o), .ex_branch_o(ex_branch_o),
    .ex_alu_op_o(ex_alu_op_o), .stall_o(stall_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always_comb begin
    act = '{valid: ex_valid_o, rs: ex_rs_o, rt: ex_rt_o, rd: ex_rd_o, uses_rt: ex_uses_rt_o,
            rs_data: ex_rs_data_o, rt_data: ex_rt_data_o, imm: ex_imm_o,
            reg_write: ex_reg_write_o, mem_read: ex_mem_read_o, mem_write: ex_mem_write_o,
            mem_to_reg: ex_mem_to_reg_o, alu_src: ex_alu_src_o, reg_dst: ex_reg_dst_o,
            branch: ex_branch_o, alu_op: ex_alu_op_o};
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Instruction builders.
  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic uses_rt, input logic is_load);
    in_t x;
    x = '0;
    x.valid     = 1'b1;
    x.rs        = rs;
    x.rt        = rt;
    x.rd        = rd;
    x.uses_rt   = uses_rt;
    x.rs_data   = $urandom;
    x.rt_data   = $urandom;
    x.imm       = $urandom;
    x.reg_write = 1'b1;
    x.mem_read  = is_load;
    x.mem_to_reg= is_load;
    x.alu_src   = !uses_rt;
    x.reg_dst   = uses_rt && !is_load;
    x.alu_op    = 4'd0;
    return x;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x = '0;
    x.rst        = ($urandom_range(0, 49) == 0);
    x.valid      = ($urandom_range(0, 7) != 0);
    x.rs         = 5'($urandom_range(0, 3));
    x.rt         = 5'($urandom_range(0, 3));
    x.rd         = 5'($urandom);
    x.uses_rt    = 1'($urandom);
    x.rs_data    = $urandom;
    x.rt_data    = $urandom;
    x.imm        = $urandom;
    x.reg_write  = 1'($urandom);
    x.mem_read   = ($urandom_range(0, 2) == 0);
    x.mem_write  = 1'($urandom);
    x.mem_to_reg = 1'($urandom);
    x.alu_src    = 1'($urandom);
    x.reg_dst    = 1'($urandom);
    x.branch     = 1'($urandom);
    x.alu_op     = 4'($urandom);
    x.flush      = ($urandom_range(0, 9) == 0);
    x.hold       = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  // Reference: what EX should hold after capturing instruction x.
  function automatic ex_t captured(input in_t x);
    ex_t e;
    e = '0;
    e.valid   = x.valid;
    e.rs      = x.rs;
    e.rt      = x.rt;
    e.rd      = x.rd;
    e.uses_rt = x.uses_rt;
    e.rs_data = x.rs_data;
    e.rt_data = x.rt_data;
    e.imm     = x.imm;
    if (x.valid) begin
      e.reg_write  = x.reg_write;
      e.mem_read   = x.mem_read;
      e.mem_write  = x.mem_write;
      e.mem_to_reg = x.mem_to_reg;
      e.alu_src    = x.alu_src;
      e.reg_dst    = x.reg_dst;
      e.branch     = x.branch;
      e.alu_op     = x.alu_op;
    end
    return e;
  endfunction

  // One cycle: drive, check stall mid-cycle, clock, check registered state.
  task automatic step(input in_t x, input bit use_tbl, input logic es, input logic ev,
                      input logic [4:0] ers, input string tag);
    logic hazard, exp_stall;
    cur = x;
    #4;
    hazard = m.valid && m.mem_read && (m.rt != 0) && x.valid &&
             ((m.rt == x.rs) || (x.uses_rt && (m.rt == x.rt)));
    exp_stall = hazard && !x.flush && !x.hold;
    if (primed) chk({tag, ".stall"}, 128'(stall_o), 128'(exp_stall));
    if (use_tbl) chk({tag, ".tbl_stall"}, 128'(stall_o), 128'(es));
    @(posedge clk);
    primed = 1'b1;
    if (x.rst) begin
      m = '0;
      m_cnt = '0;
    end else if (x.flush) begin
      m = '0;
    end else if (x.hold) begin
      m = m;
    end else if (hazard) begin
      m = '0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m = captured(x);
    end
    #1;
    chk({tag, ".ex"}, 128'(act), 128'(m));
    if (use_tbl) begin
      chk({tag, ".tbl_valid"}, 128'(ex_valid_o), 128'(ev));
      chk({tag, ".tbl_rs"}, 128'(ex_rs_o), 128'(ers));
    end
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, ".cnt"}, 128'(stall_cnt_o), 128'(m_cnt));
`endif
  endtask

  vec_t tbl[$];

  function automatic vec_t v(input in_t x, input logic es, input logic ev, input logic [4:0] ers);
    vec_t r;
    r.in = x; r.exp_stall = es; r.exp_valid = ev; r.exp_rs = ers;
    return r;
  endfunction

  initial begin
    in_t x;
    @(posedge clk); #1;

    // Reset 2 cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      x = rnd_in();
      x.rst = 1'b1;
      step(x, 1'b0, 1'b0, 1'b0, 5'd0, "reset");
    end
    #4;
    chk("reset.stall_zero", 128'(stall_o), 128'(1'b0));
    #6;

    // Directed table.
    tbl.push_back(v(mk(1, 8, 0, 0, 1), 0, 1, 1));              // lw $8
    tbl.push_back(v(mk(8, 10, 9, 1, 0), 1, 0, 0));             // add $9,$8,$10 -> stall
    tbl.push_back(v(mk(8, 10, 9, 1, 0), 0, 1, 8));             // add enters EX
    tbl.push_back(v(mk(1, 0, 0, 0, 1), 0, 1, 1));              // lw $0
    tbl.push_back(v(mk(0, 0, 9, 1, 0), 0, 1, 0));              // reads $0: no stall
    tbl.push_back(v(mk(1, 8, 0, 0, 1), 0, 1, 1));              // lw $8
    tbl.push_back(v(mk(8, 9, 0, 0, 0), 1, 0, 0));              // addi rs match
    tbl.push_back(v(mk(8, 9, 0, 0, 0), 0, 1, 8));
    tbl.push_back(v(mk(1, 8, 0, 0, 1), 0, 1, 1));              // lw $8
    tbl.push_back(v(mk(3, 8, 0, 0, 0), 0, 1, 3));              // rt match, uses_rt=0
    tbl.push_back(v(mk(1, 8, 0, 0, 1), 0, 1, 1));              // lw $8
    x = mk(8, 10, 9, 1, 0); x.flush = 1'b1;
    tbl.push_back(v(x, 0, 0, 0));                              // hazard + flush
    tbl.push_back(v(mk(8, 10, 9, 1, 0), 0, 1, 8));             // after flush bubble
    tbl.push_back(v(mk(1, 8, 0, 0, 1), 0, 1, 1));              // lw $8
    x = mk(8, 10, 9, 1, 0); x.hold = 1'b1;
    tbl.push_back(v(x, 0, 1, 1));                              // hold 1
    x = mk(8, 5, 7, 1, 0); x.hold = 1'b1;
    tbl.push_back(v(x, 0, 1, 1));                              // hold 2
    x = mk(2, 8, 6, 1, 0); x.hold = 1'b1;
    tbl.push_back(v(x, 0, 1, 1));                              // hold 3
    tbl.push_back(v(mk(8, 10, 9, 1, 0), 1, 0, 0));             // hazard after hold
    tbl.push_back(v(mk(8, 10, 9, 1, 0), 0, 1, 8));
    foreach (tbl[i]) step(tbl[i].in, 1'b1, tbl[i].exp_stall, tbl[i].exp_valid,
                          tbl[i].exp_rs, $sformatf("vec%0d", i));

    // Reset in the middle of a stall: nothing remembered.
    step(mk(1, 8, 0, 0, 1), 1'b0, 1'b0, 1'b0, 5'd0, "mid.lw");
    x = mk(8, 10, 9, 1, 0); x.rst = 1'b1;
    step(x, 1'b1, 1'b1, 1'b0, 5'd0, "mid.rst");
    step(mk(8, 10, 9, 1, 0), 1'b1, 1'b0, 1'b1, 5'd8, "mid.after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) step(rnd_in(), 1'b0, 1'b0, 1'b0, 5'd0, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
